// File: rtl/spi_pkg.sv
// Shared types and constants for the parametrised SPI slave.
package spi_pkg;

  localparam int unsigned ST_W = 8;

  // One-hot FSM state encoding
  typedef enum logic [ST_W-1:0] {
    IDLE      = 8'b0000_0001,
    CHK_CMD   = 8'b0000_0010,
    WRITE     = 8'b0000_0100,
    READ_ADD  = 8'b0000_1000,
    READ_DATA = 8'b0001_0000,
    TX_WAIT   = 8'b0010_0000,
    TX_SHIFT  = 8'b0100_0000,
    DRAIN     = 8'b1000_0000
  } state_t;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_slave_gen_if.sv
// SPI pins plus RAM-side parallel handshake of the SPI slave.
interface spi_slave_gen_if #(
  parameter int unsigned DATA_W = 8
);
  localparam int unsigned FW = DATA_W + 2;

  logic              SS_n;
  logic              MOSI;
  logic              MISO;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic [FW-1:0]     rx_data;
  logic              rx_valid;
  logic              err;
  logic              busy;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid, err, busy
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid, err, busy
  );

endinterface

// File: rtl/spi_piso.sv
// Parallel-in serial-out register feeding MISO, MSB first.
module spi_piso #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift_en,
  input  logic [DATA_W-1:0] din,
  output logic              msb
);

  logic [DATA_W-1:0] sr;

  // Load has priority; shifting moves the next bit into the MSB slot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift_en) begin
      sr <= sr << 1;
    end
  end

  assign msb = sr[DATA_W-1];

endmodule

// File: rtl/spi_slave_gen.sv
// SPI slave front-end: deserialises {opcode, payload} frames, serialises read data.
module spi_slave_gen
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned TX_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_slave_gen_if.slave    bus
);

  localparam int unsigned FW    = DATA_W + 2;
  localparam int unsigned CNT_W = $clog2(FW + 1);
  localparam int unsigned TO_W  = $clog2(TX_TIMEOUT + 1);

  state_t           state;
  logic [FW-2:0]    shift;
  logic [CNT_W-1:0] cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             rd_addr_done;
  logic             piso_load;
  logic             piso_shift;
  logic             piso_msb;

  assign piso_load  = (state == TX_WAIT)  && !bus.SS_n && bus.tx_valid;
  assign piso_shift = (state == TX_SHIFT) && !bus.SS_n;

  spi_piso #(.DATA_W(DATA_W)) u_piso (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (piso_load),
    .shift_en (piso_shift),
    .din      (bus.tx_data),
    .msb      (piso_msb)
  );

  // Frame FSM with registered outputs; busy tracks the next state leaving IDLE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      shift        <= '0;
      cnt          <= '0;
      to_cnt       <= '0;
      rd_addr_done <= 1'b0;
      bus.rx_data  <= '0;
      bus.rx_valid <= 1'b0;
      bus.MISO     <= 1'b0;
      bus.err      <= 1'b0;
      bus.busy     <= 1'b0;
    end else begin
      bus.rx_valid <= 1'b0;
      bus.err      <= 1'b0;
      bus.MISO     <= 1'b0;
      bus.busy     <= 1'b1;
      unique case (state)
        IDLE: begin
          if (!bus.SS_n) begin
            state <= CHK_CMD;
            cnt   <= '0;
          end else begin
            bus.busy <= 1'b0;
          end
        end
        CHK_CMD: begin
          if (bus.SS_n) begin
            state    <= IDLE;
            bus.err  <= 1'b1;
            bus.busy <= 1'b0;
          end else begin
            shift <= {shift[FW-3:0], bus.MOSI};
            cnt   <= cnt + CNT_W'(1);
            if (!bus.MOSI)        state <= WRITE;
            else if (rd_addr_done) state <= READ_DATA;
            else                   state <= READ_ADD;
          end
        end
        WRITE, READ_ADD, READ_DATA: begin
          if (cnt == CNT_W'(FW - 1)) begin
            // Final bit counts even if SS_n rises on the same edge
            bus.rx_data  <= {shift, bus.MOSI};
            bus.rx_valid <= 1'b1;
            cnt          <= cnt + CNT_W'(1);
            if (state == READ_ADD) rd_addr_done <= 1'b1;
            if (bus.SS_n) begin
              state    <= IDLE;
              bus.busy <= 1'b0;
            end else if (state == READ_DATA) begin
              state  <= TX_WAIT;
              to_cnt <= '0;
            end else begin
              state <= DRAIN;
            end
          end else if (bus.SS_n) begin
            state    <= IDLE;
            bus.err  <= 1'b1;
            bus.busy <= 1'b0;
          end else if ((cnt == CNT_W'(1)) &&
                       (((state == READ_ADD)  && (bus.MOSI != OP_RD_ADDR[0])) ||
                        ((state == READ_DATA) && (bus.MOSI != OP_RD_DATA[0])))) begin
            bus.err <= 1'b1;
            state   <= DRAIN;
          end else begin
            shift <= {shift[FW-3:0], bus.MOSI};
            cnt   <= cnt + CNT_W'(1);
          end
        end
        TX_WAIT: begin
          if (bus.SS_n) begin
            state    <= IDLE;
            bus.err  <= 1'b1;
            bus.busy <= 1'b0;
          end else if (bus.tx_valid) begin
            state <= TX_SHIFT;
            cnt   <= '0;
          end else if (to_cnt == TO_W'(TX_TIMEOUT - 1)) begin
            bus.err      <= 1'b1;
            state        <= DRAIN;
            rd_addr_done <= 1'b0;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        TX_SHIFT: begin
          if (bus.SS_n) begin
            state    <= IDLE;
            bus.err  <= 1'b1;
            bus.busy <= 1'b0;
          end else begin
            bus.MISO <= piso_msb;
            cnt      <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(DATA_W - 1)) begin
              state        <= DRAIN;
              rd_addr_done <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (bus.SS_n) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_gen.sv
// Scoreboard bench for spi_slave_gen with DATA_W=8, TX_TIMEOUT=16.
module tb_spi_slave_gen;

  localparam int unsigned DW = 8;
  localparam int unsigned FW = DW + 2;

  typedef struct packed {
    logic          is_err;
    logic [FW-1:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_slave_gen_if #(.DATA_W(DW)) bus ();

  spi_slave_gen #(.DATA_W(DW), .TX_TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int   n_total = 0;
  int   n_pass  = 0;
  ev_t  exp_q[$];
  ev_t  mon_e;
  logic miso_or;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  task automatic exp_rx(input logic [FW-1:0] d);
    exp_q.push_back('{is_err: 1'b0, data: d});
  endtask

  task automatic exp_err();
    exp_q.push_back('{is_err: 1'b1, data: '0});
  endtask

  // Pop and compare whenever the DUT reports a frame or an error
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.rx_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL sb_rx_unexpected: got rx_valid with rx_data 0x%0h, expected no event", bus.rx_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_rx_kind", 32'(mon_e.is_err), 32'd0);
          chk("sb_rx_data", 32'(bus.rx_data), 32'(mon_e.data));
        end
      end
      if (bus.err === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL sb_err_unexpected: got err pulse, expected no event");
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_err_kind", 32'(mon_e.is_err), 32'd1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_frame();
    bus.SS_n = 1'b0;
    bus.MOSI = 1'b0;
    tick();
  endtask

  task automatic end_frame();
    bus.SS_n = 1'b1;
    bus.MOSI = 1'b0;
    tick();
  endtask

  task automatic send_bits(input logic [FW-1:0] f, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      bus.MOSI = f[FW-1-i];
      tick();
      miso_or = miso_or | bus.MISO;
    end
  endtask

  task automatic full_frame(input logic [FW-1:0] f);
    begin_frame();
    send_bits(f, 0, FW - 1);
  endtask

  logic [DW-1:0] txb;
  logic [FW-1:0] fr;

  initial begin
    rst_n        = 1'b0;
    bus.SS_n     = 1'b1;
    bus.MOSI     = 1'b0;
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    miso_or      = 1'b0;
    repeat (3) tick();
    chk("rst_rx_data", 32'(bus.rx_data), 32'd0);
    chk("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    chk("rst_miso", 32'(bus.MISO), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    tick();

    // Write address frame, extra bits fall into DRAIN
    exp_rx(10'h0A5);
    miso_or = 1'b0;
    begin_frame();
    chk("wr_busy_start", 32'(bus.busy), 32'd1);
    send_bits(10'b00_1010_0101, 0, FW - 1);
    chk("wr_rx_valid", 32'(bus.rx_valid), 32'd1);
    chk("wr_rx_data", 32'(bus.rx_data), 32'h0A5);
    send_bits(10'h3FF, 0, 1);
    chk("wr_rx_valid_pulse", 32'(bus.rx_valid), 32'd0);
    chk("wr_rx_data_hold", 32'(bus.rx_data), 32'h0A5);
    chk("wr_busy_drain", 32'(bus.busy), 32'd1);
    chk("wr_miso_quiet", 32'(miso_or), 32'd0);
    end_frame();
    chk("wr_busy_end", 32'(bus.busy), 32'd0);

    // Read address then read data with MISO serialisation of 0xC3
    exp_rx(10'h23C);
    full_frame(10'b10_0011_1100);
    end_frame();
    exp_rx(10'h300);
    full_frame(10'b11_0000_0000);
    chk("rd_busy_wait", 32'(bus.busy), 32'd1);
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'h5A;
    bus.tx_valid = 1'b0;
    repeat (3) tick();
    chk("rd_miso_wait", 32'(bus.MISO), 32'd0);
    txb          = 8'hC3;
    bus.tx_data  = txb;
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    chk("rd_miso_load", 32'(bus.MISO), 32'd0);
    for (int i = 0; i < int'(DW); i++) begin
      tick();
      chk($sformatf("rd_miso_bit%0d", i), 32'(bus.MISO), 32'(txb[DW-1-i]));
    end
    tick();
    chk("rd_miso_done", 32'(bus.MISO), 32'd0);
    end_frame();

    // Opcode mismatch: 11 frame with no pending read address
    exp_err();
    full_frame(10'b11_0101_0101);
    chk("mm_busy_drain", 32'(bus.busy), 32'd1);
    chk("mm_rx_data_hold", 32'(bus.rx_data), 32'h300);
    end_frame();
    chk("mm_busy_end", 32'(bus.busy), 32'd0);

    // Abort after five bits of a write frame
    exp_err();
    begin_frame();
    send_bits(10'b01_1111_0000, 0, 4);
    bus.SS_n = 1'b1;
    tick();
    chk("ab_busy", 32'(bus.busy), 32'd0);
    chk("ab_rx_data_hold", 32'(bus.rx_data), 32'h300);
    chk("ab_miso", 32'(bus.MISO), 32'd0);
    tick();

    // SS_n rising together with the last bit still completes the frame
    exp_rx(10'h1C3);
    fr = 10'b01_1100_0011;
    begin_frame();
    send_bits(fr, 0, FW - 2);
    bus.MOSI = fr[0];
    bus.SS_n = 1'b1;
    tick();
    chk("last_rx_valid", 32'(bus.rx_valid), 32'd1);
    chk("last_busy", 32'(bus.busy), 32'd0);
    chk("last_err", 32'(bus.err), 32'd0);
    tick();

    // Read-data timeout at edge FW+16
    exp_rx(10'h201);
    full_frame(10'b10_0000_0001);
    end_frame();
    exp_rx(10'h3FF);
    exp_err();
    full_frame(10'b11_1111_1111);
    repeat (15) tick();
    chk("to_err_early", 32'(bus.err), 32'd0);
    tick();
    chk("to_err", 32'(bus.err), 32'd1);
    chk("to_miso", 32'(bus.MISO), 32'd0);
    chk("to_busy_drain", 32'(bus.busy), 32'd1);
    end_frame();
    exp_rx(10'h255);
    full_frame(10'b10_0101_0101);
    end_frame();

    // Reset in the middle of TX_SHIFT
    exp_rx(10'h300);
    full_frame(10'b11_0000_0000);
    txb          = 8'hA5;
    bus.tx_data  = txb;
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rs_miso_bit%0d", i), 32'(bus.MISO), 32'(txb[DW-1-i]));
    end
    rst_n = 1'b0;
    tick();
    chk("rs_miso", 32'(bus.MISO), 32'd0);
    chk("rs_busy", 32'(bus.busy), 32'd0);
    chk("rs_rx_data", 32'(bus.rx_data), 32'd0);
    chk("rs_rx_valid", 32'(bus.rx_valid), 32'd0);
    chk("rs_err", 32'(bus.err), 32'd0);
    bus.SS_n = 1'b1;
    rst_n    = 1'b1;
    tick();
    exp_rx(10'h2AA);
    full_frame(10'b10_1010_1010);
    end_frame();

    repeat (2) tick();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
